// File: rtl/unsigned_divide_pkg.sv
// Shared types and constants for the radix-2 restoring unsigned divider.
// Sized for the largest legal WIDTH so every instance can share them.
package unsigned_divide_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int MAX_WIDTH = 32;

    // Wide enough to hold WIDTH-1 for any legal WIDTH.
    localparam int CNT_W = $clog2(MAX_WIDTH);

    localparam logic [MAX_WIDTH-1:0] ALL_ONES = '1;

endpackage

// File: rtl/unsigned_divide_step.sv
// One restoring-division iteration: shift in the next dividend bit, then
// trial-subtract the divisor at WIDTH+1 bits so large divisors cannot overflow.
module unsigned_divide_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] r_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] r_next_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted  = {r_i, bit_i};
        diff     = shifted - {1'b0, divisor_i};
        q_bit_o  = (shifted >= {1'b0, divisor_i});
        r_next_o = q_bit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/unsigned_divide.sv
// Sequential unsigned divider, one quotient bit per clock, with start/done
// handshake; divide by zero completes in one cycle with an all-ones quotient.
module unsigned_divide
    import unsigned_divide_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dataa,
    input  logic [WIDTH-1:0] datab,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    state_e             state_q,  state_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic [WIDTH-1:0]   rem_q,    rem_d;
    logic [WIDTH-1:0]   shift_q,  shift_d;
    logic [WIDTH-1:0]   div_q,    div_d;
    logic [WIDTH-1:0]   quot_q,   quot_d;
    logic [WIDTH-1:0]   remout_q, remout_d;
    logic               dbz_q,    dbz_d;
    logic               done_q,   done_d;

    logic [WIDTH-1:0]   step_r;
    logic               step_q;

    unsigned_divide_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .r_i       (rem_q),
        .bit_i     (shift_q[WIDTH-1]),
        .divisor_i (div_q),
        .r_next_o  (step_r),
        .q_bit_o   (step_q)
    );

    // The shift register holds unconsumed dividend bits at the top and the
    // quotient bits produced so far at the bottom.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rem_d    = rem_q;
        shift_d  = shift_q;
        div_d    = div_q;
        quot_d   = quot_q;
        remout_d = remout_q;
        dbz_d    = dbz_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    div_d = datab;
                    if (datab == '0) begin
                        quot_d   = ALL_ONES[WIDTH-1:0];
                        remout_d = dataa;
                        dbz_d    = 1'b1;
                        done_d   = 1'b1;
                    end else begin
                        rem_d   = '0;
                        shift_d = dataa;
                        count_d = CNT_W'(WIDTH - 1);
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                rem_d   = step_r;
                shift_d = {shift_q[WIDTH-2:0], step_q};
                count_d = count_q - CNT_W'(1);
                if (count_q == '0) begin
                    quot_d   = {shift_q[WIDTH-2:0], step_q};
                    remout_d = step_r;
                    dbz_d    = 1'b0;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            rem_q    <= '0;
            shift_q  <= '0;
            div_q    <= '0;
            quot_q   <= '0;
            remout_q <= '0;
            dbz_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rem_q    <= rem_d;
            shift_q  <= shift_d;
            div_q    <= div_d;
            quot_q   <= quot_d;
            remout_q <= remout_d;
            dbz_q    <= dbz_d;
            done_q   <= done_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = remout_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_unsigned_divide.sv
// Directed plus random bench for unsigned_divide: expected results are queued
// when a request is issued and checked by a monitor whenever done pulses.
module tb_unsigned_divide;

    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dbz;
    } result_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] dataa;
    logic [WIDTH-1:0] datab;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    result_t sb[$];
    int nChecks   = 0;
    int nFails    = 0;
    int doneCount = 0;

    unsigned_divide #(
        .WIDTH(WIDTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dataa       (dataa),
        .datab       (datab),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp)
        else begin
            nFails++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Golden model: quotient/remainder from the language operators.
    function automatic result_t golden(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        result_t res;
        if (b == '0) begin
            res.q   = '1;
            res.r   = a;
            res.dbz = 1'b1;
        end else begin
            res.q   = a / b;
            res.r   = a % b;
            res.dbz = 1'b0;
        end
        return res;
    endfunction

    // Drives a one-cycle start pulse from a negedge; the next posedge accepts it.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit expectAccept);
        @(negedge clk);
        start = 1'b1;
        dataa = a;
        datab = b;
        if (expectAccept) sb.push_back(golden(a, b));
        @(negedge clk);
        start = 1'b0;
        dataa = $urandom_range(255, 0);
        datab = $urandom_range(255, 0);
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (sb.size() > 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("drain_timeout", sb.size(), 0);
        sb.delete();
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            doneCount++;
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", done, 0);
            end else begin
                result_t e;
                e = sb.pop_front();
                checkOutput("quotient", quotient, e.q);
                checkOutput("remainder", remainder, e.r);
                checkOutput("div_by_zero", div_by_zero, e.dbz);
                checkOutput("busy_at_done", busy, 0);
            end
        end
    end

    initial begin
        int dc;
        reset = 1'b1;
        start = 1'b1;
        dataa = 8'd100;
        datab = 8'd7;

        $display("[TB] reset with start held high");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_done", done, 0);
            checkOutput("rst_quot", quotient, 0);
            checkOutput("rst_rem", remainder, 0);
        end
        start = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("post_rst_busy", busy, 0);
        checkOutput("post_rst_done", done, 0);
        checkOutput("post_rst_quot", quotient, 0);
        checkOutput("post_rst_rem", remainder, 0);

        $display("[TB] 100/7 latency");
        applyStimulus(8'd100, 8'd7, 1'b1);
        for (int i = 0; i < 7; i++) begin
            checkOutput("run_busy", busy, 1);
            checkOutput("run_done", done, 0);
            @(negedge clk);
        end
        checkOutput("run_busy_last", busy, 1);
        @(negedge clk);
        #1;
        checkOutput("latency_done", done, 1);
        checkOutput("latency_busy", busy, 0);
        @(negedge clk);
        checkOutput("done_one_cycle", done, 0);
        checkOutput("hold_quot", quotient, 14);
        checkOutput("hold_rem", remainder, 2);
        waitIdle(4);

        $display("[TB] boundary operands");
        applyStimulus(8'd255, 8'd1, 1'b1);
        waitIdle(20);
        applyStimulus(8'd3, 8'd200, 1'b1);
        waitIdle(20);
        applyStimulus(8'd255, 8'd255, 1'b1);
        waitIdle(20);
        applyStimulus(8'd200, 8'd128, 1'b1);
        waitIdle(20);

        $display("[TB] divide by zero");
        applyStimulus(8'd5, 8'd0, 1'b1);
        #1;
        checkOutput("dbz_done", done, 1);
        checkOutput("dbz_busy", busy, 0);
        @(negedge clk);
        checkOutput("dbz_done_drop", done, 0);
        checkOutput("dbz_busy_after", busy, 0);
        checkOutput("dbz_hold_flag", div_by_zero, 1);
        checkOutput("dbz_hold_quot", quotient, 255);
        waitIdle(4);
        applyStimulus(8'd9, 8'd3, 1'b1);
        waitIdle(20);
        checkOutput("dbz_cleared", div_by_zero, 0);

        $display("[TB] start during RUN is ignored");
        dc = doneCount;
        applyStimulus(8'd50, 8'd5, 1'b1);
        repeat (2) @(negedge clk);
        applyStimulus(8'd99, 8'd9, 1'b0);
        waitIdle(20);
        repeat (12) @(negedge clk);
        checkOutput("single_done", doneCount - dc, 1);

        $display("[TB] start held across done");
        @(negedge clk);
        start = 1'b1;
        dataa = 8'd20;
        datab = 8'd4;
        sb.push_back(golden(8'd20, 8'd4));
        @(negedge clk);
        dataa = 8'd30;
        datab = 8'd6;
        sb.push_back(golden(8'd30, 8'd6));
        dc = doneCount;
        for (int i = 0; i < 20 && doneCount == dc; i++) begin
            @(negedge clk);
            #1;
        end
        checkOutput("first_done_seen", doneCount - dc, 1);
        @(negedge clk);
        start = 1'b0;
        checkOutput("zero_bubble_busy", busy, 1);
        waitIdle(20);

        $display("[TB] reset aborts a division");
        applyStimulus(8'd200, 8'd3, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_quot", quotient, 0);
        checkOutput("abort_rem", remainder, 0);
        checkOutput("abort_dbz", div_by_zero, 0);
        dc = doneCount;
        repeat (12) @(negedge clk);
        checkOutput("abort_no_done", doneCount - dc, 0);

        $display("[TB] random operands");
        for (int i = 0; i < 100; i++) begin
            applyStimulus(WIDTH'($urandom_range(255, 0)), WIDTH'($urandom_range(255, 1)), 1'b1);
            waitIdle(20);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
